// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multicycle MIPS main control unit:
// state codes, opcodes and the control-word bundle.
package mips_ctrl_pkg;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMRD    = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWR    = 4'd5,
        S_RTYPE_EX = 4'd6,
        S_RTYPE_WB = 4'd7,
        S_BEQ_EX   = 4'd8,
        S_JUMP_EX  = 4'd9,
        S_ADDI_EX  = 4'd10,
        S_ADDI_WB  = 4'd11
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;

    localparam logic [1:0] ALU_ADD   = 2'b00;
    localparam logic [1:0] ALU_SUB   = 2'b01;
    localparam logic [1:0] ALU_FUNCT = 2'b10;

    localparam logic [1:0] SRCB_REG    = 2'b00;
    localparam logic [1:0] SRCB_FOUR   = 2'b01;
    localparam logic [1:0] SRCB_IMM    = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic       iord;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       mem_to_reg;
        logic       reg_dst;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic [1:0] pc_source;
    } ctrl_t;

endpackage

// File: rtl/control_decode.sv
// Moore output decode: maps the current state to its control word.
// Any state without an explicit entry yields an all-zero word.
module control_decode
    import mips_ctrl_pkg::*;
(
    input  state_t state,
    output ctrl_t  ctrl
);

    always_comb begin
        ctrl = '0;
        case (state)
            S_FETCH: begin
                ctrl.mem_read  = 1'b1;
                ctrl.ir_write  = 1'b1;
                ctrl.pc_write  = 1'b1;
                ctrl.alu_src_b = SRCB_FOUR;
                ctrl.alu_op    = ALU_ADD;
                ctrl.pc_source = PCSRC_ALU;
            end
            S_DECODE: begin
                ctrl.alu_src_b = SRCB_IMM_SH;
            end
            S_MEMADR, S_ADDI_EX: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_IMM;
            end
            S_MEMRD: begin
                ctrl.mem_read = 1'b1;
                ctrl.iord     = 1'b1;
            end
            S_MEMWB: begin
                ctrl.reg_write  = 1'b1;
                ctrl.mem_to_reg = 1'b1;
            end
            S_MEMWR: begin
                ctrl.mem_write = 1'b1;
                ctrl.iord      = 1'b1;
            end
            S_RTYPE_EX: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_REG;
                ctrl.alu_op    = ALU_FUNCT;
            end
            S_RTYPE_WB: begin
                ctrl.reg_write = 1'b1;
                ctrl.reg_dst   = 1'b1;
            end
            S_BEQ_EX: begin
                ctrl.alu_src_a     = 1'b1;
                ctrl.alu_op        = ALU_SUB;
                ctrl.pc_write_cond = 1'b1;
                ctrl.pc_source     = PCSRC_ALUOUT;
            end
            S_JUMP_EX: begin
                ctrl.pc_write  = 1'b1;
                ctrl.pc_source = PCSRC_JUMP;
            end
            S_ADDI_WB: begin
                ctrl.reg_write = 1'b1;
            end
            default: ctrl = '0;
        endcase
    end

endmodule

// File: rtl/main_control_fsm.sv
// Multicycle MIPS main control: state register, opcode-driven
// next-state logic and the Moore control outputs.
module main_control_fsm
    import mips_ctrl_pkg::*;
#(
    parameter int STATE_W = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [5:0]         Opcode,
    output logic               PCWrite,
    output logic               PCWriteCond,
    output logic               IorD,
    output logic               MemRead,
    output logic               MemWrite,
    output logic               IRWrite,
    output logic               MemtoReg,
    output logic               RegDst,
    output logic               RegWrite,
    output logic               ALUSrcA,
    output logic [1:0]         ALUSrcB,
    output logic [1:0]         ALUOp,
    output logic [1:0]         PCSource,
    output logic [STATE_W-1:0] State
);

    state_t state;
    state_t state_next;
    ctrl_t  ctrl;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= S_FETCH;
        else       state <= state_next;
    end

    // Opcode only matters in DECODE and MEMADR
    always_comb begin
        state_next = S_FETCH;
        case (state)
            S_FETCH: state_next = S_DECODE;
            S_DECODE: begin
                case (Opcode)
                    OP_LW, OP_SW: state_next = S_MEMADR;
                    OP_RTYPE:     state_next = S_RTYPE_EX;
                    OP_BEQ:       state_next = S_BEQ_EX;
                    OP_J:         state_next = S_JUMP_EX;
                    OP_ADDI:      state_next = S_ADDI_EX;
                    default:      state_next = S_FETCH;
                endcase
            end
            S_MEMADR:
                state_next = (Opcode == OP_LW) ? S_MEMRD : S_MEMWR;
            S_MEMRD:    state_next = S_MEMWB;
            S_RTYPE_EX: state_next = S_RTYPE_WB;
            S_ADDI_EX:  state_next = S_ADDI_WB;
            default:    state_next = S_FETCH;
        endcase
    end

    control_decode u_decode (
        .state (state),
        .ctrl  (ctrl)
    );

    assign PCWrite     = ctrl.pc_write;
    assign PCWriteCond = ctrl.pc_write_cond;
    assign IorD        = ctrl.iord;
    assign MemRead     = ctrl.mem_read;
    assign MemWrite    = ctrl.mem_write;
    assign IRWrite     = ctrl.ir_write;
    assign MemtoReg    = ctrl.mem_to_reg;
    assign RegDst      = ctrl.reg_dst;
    assign RegWrite    = ctrl.reg_write;
    assign ALUSrcA     = ctrl.alu_src_a;
    assign ALUSrcB     = ctrl.alu_src_b;
    assign ALUOp       = ctrl.alu_op;
    assign PCSource    = ctrl.pc_source;
    assign State       = state;

endmodule

// File: tb/tb_main_control_fsm.sv
// Randomized self-checking bench for main_control_fsm against an
// instruction-level model (state path and control word per step).
module tb_main_control_fsm;

    typedef int q_t[$];

    logic       clk = 1'b0;
    logic       reset;
    logic [5:0] Opcode;
    logic       PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite;
    logic       MemtoReg, RegDst, RegWrite, ALUSrcA;
    logic [1:0] ALUSrcB, ALUOp, PCSource;
    logic [3:0] State;

    int n_cmp = 0;
    int n_bad = 0;

    main_control_fsm #(.STATE_W(4)) dut (
        .clk         (clk),
        .reset       (reset),
        .Opcode      (Opcode),
        .PCWrite     (PCWrite),
        .PCWriteCond (PCWriteCond),
        .IorD        (IorD),
        .MemRead     (MemRead),
        .MemWrite    (MemWrite),
        .IRWrite     (IRWrite),
        .MemtoReg    (MemtoReg),
        .RegDst      (RegDst),
        .RegWrite    (RegWrite),
        .ALUSrcA     (ALUSrcA),
        .ALUSrcB     (ALUSrcB),
        .ALUOp       (ALUOp),
        .PCSource    (PCSource),
        .State       (State)
    );

    always #5 clk = ~clk;

    // Observed control word, fixed field order
    function automatic logic [15:0] obs();
        return {PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite,
                MemtoReg, RegDst, RegWrite, ALUSrcA,
                ALUSrcB, ALUOp, PCSource};
    endfunction

    // Build expected word from named fields
    function automatic logic [15:0] mk(bit pcw, bit pcwc, bit iord,
                                       bit mrd, bit mwr, bit irw,
                                       bit m2r, bit rdst, bit rw,
                                       bit srca, logic [1:0] srcb,
                                       logic [1:0] aop, logic [1:0] pcs);
        return {pcw, pcwc, iord, mrd, mwr, irw, m2r, rdst, rw, srca,
                srcb, aop, pcs};
    endfunction

    // Required outputs of each state
    function automatic logic [15:0] exp_ctrl(int s);
        case (s)
            0:  return mk(1,0,0,1,0,1,0,0,0,0,2'b01,2'b00,2'b00);
            1:  return mk(0,0,0,0,0,0,0,0,0,0,2'b11,2'b00,2'b00);
            2:  return mk(0,0,0,0,0,0,0,0,0,1,2'b10,2'b00,2'b00);
            3:  return mk(0,0,1,1,0,0,0,0,0,0,2'b00,2'b00,2'b00);
            4:  return mk(0,0,0,0,0,0,1,0,1,0,2'b00,2'b00,2'b00);
            5:  return mk(0,0,1,0,1,0,0,0,0,0,2'b00,2'b00,2'b00);
            6:  return mk(0,0,0,0,0,0,0,0,0,1,2'b00,2'b10,2'b00);
            7:  return mk(0,0,0,0,0,0,0,1,1,0,2'b00,2'b00,2'b00);
            8:  return mk(0,1,0,0,0,0,0,0,0,1,2'b00,2'b01,2'b01);
            9:  return mk(1,0,0,0,0,0,0,0,0,0,2'b00,2'b00,2'b10);
            10: return mk(0,0,0,0,0,0,0,0,0,1,2'b10,2'b00,2'b00);
            11: return mk(0,0,0,0,0,0,0,0,1,0,2'b00,2'b00,2'b00);
            default: return 16'h0000;
        endcase
    endfunction

    // Instruction-level model: states visited from FETCH
    function automatic q_t path(logic [5:0] op);
        case (op)
            6'b100011: return '{0, 1, 2, 3, 4};
            6'b101011: return '{0, 1, 2, 5};
            6'b000000: return '{0, 1, 6, 7};
            6'b001000: return '{0, 1, 10, 11};
            6'b000100: return '{0, 1, 8};
            6'b000010: return '{0, 1, 9};
            default:   return '{0, 1};
        endcase
    endfunction

    function automatic int cycles(logic [5:0] op);
        case (op)
            6'b100011: return 5;
            6'b101011, 6'b000000, 6'b001000: return 4;
            6'b000100, 6'b000010: return 3;
            default: return 2;
        endcase
    endfunction

    // Run one instruction from FETCH; opcode is random garbage
    // whenever it is not being sampled.
    task automatic run_instr(input logic [5:0] op, input string tag);
        q_t q;
        int ret;
        q = path(op);
        ret = -1;
        for (int k = 0; k < q.size(); k++) begin
            n_cmp++;
            if (State !== 4'(q[k])) begin
                n_bad++;
                $display("FAIL %s state step %0d: got %0d want %0d",
                         tag, k, State, q[k]);
            end
            if (k > 0 && State === 4'd0 && ret < 0) ret = k;
            n_cmp++;
            if (obs() !== exp_ctrl(q[k])) begin
                n_bad++;
                $display("FAIL %s ctrl state %0d: got %h want %h",
                         tag, q[k], obs(), exp_ctrl(q[k]));
            end
            n_cmp++;
            if ((MemRead & MemWrite) | (PCWrite & PCWriteCond)) begin
                n_bad++;
                $display("FAIL %s exclusive strobes state %0d: got %h",
                         tag, q[k], obs());
            end
            if (q[k] == 1 || q[k] == 2) Opcode = op;
            else Opcode = 6'($urandom_range(0, 63));
            @(negedge clk);
        end
        if (ret < 0 && State === 4'd0) ret = q.size();
        n_cmp++;
        if (ret != cycles(op)) begin
            n_bad++;
            $display("FAIL %s cycle count op %b: got %0d want %0d",
                     tag, op, ret, cycles(op));
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        Opcode = 6'b000000;
        repeat (3) @(negedge clk);
        n_cmp++;
        if (State !== 4'd0 || obs() !== exp_ctrl(0)) begin
            n_bad++;
            $display("FAIL reset_hold: got state %0d ctrl %h want 0 %h",
                     State, obs(), exp_ctrl(0));
        end
        reset = 1'b0;
    endtask

    task automatic test_rtype_reset();
        Opcode = 6'b000000;
        repeat (2) @(negedge clk);
        n_cmp++;
        if (State !== 4'd6) begin
            n_bad++;
            $display("FAIL reach_rtype_ex: got %0d want 6", State);
        end
        #2 reset = 1'b1;
        #1;
        n_cmp++;
        if (State !== 4'd0 || obs() !== exp_ctrl(0)) begin
            n_bad++;
            $display("FAIL async_reset: got state %0d ctrl %h want 0 %h",
                     State, obs(), exp_ctrl(0));
        end
        @(negedge clk);
        reset = 1'b0;
        run_instr(6'b000000, "rtype_after_reset");
    endtask

    task automatic test_lw_sw();
        run_instr(6'b100011, "lw");
        run_instr(6'b101011, "sw");
        run_instr(6'b001000, "addi");
    endtask

    task automatic test_back_to_back();
        run_instr(6'b000100, "beq");
        run_instr(6'b000010, "j");
        for (int i = 0; i < 3; i++) run_instr(6'b111111, "unknown");
    endtask

    task automatic test_random();
        logic [5:0] ops[7];
        logic [5:0] op;
        ops = '{6'b100011, 6'b101011, 6'b000000, 6'b001000,
                6'b000100, 6'b000010, 6'b111111};
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 3) == 0) op = 6'($urandom_range(0, 63));
            else op = ops[$urandom_range(0, 6)];
            run_instr(op, "random");
        end
    endtask

    // Reset at a random point inside a random instruction
    task automatic test_reset_any();
        logic [5:0] ops[6];
        logic [5:0] op;
        int steps;
        ops = '{6'b100011, 6'b101011, 6'b000000, 6'b001000,
                6'b000100, 6'b000010};
        for (int i = 0; i < 12; i++) begin
            op = ops[$urandom_range(0, 5)];
            steps = $urandom_range(1, cycles(op) - 1);
            Opcode = op;
            repeat (steps) @(negedge clk);
            #($urandom_range(1, 3)) reset = 1'b1;
            #1;
            n_cmp++;
            if (State !== 4'd0) begin
                n_bad++;
                $display("FAIL reset_any op %b step %0d: got %0d want 0",
                         op, steps, State);
            end
            @(negedge clk);
            reset = 1'b0;
            run_instr(6'b100011, "lw_after_reset");
        end
    endtask

    initial begin
        reset = 1'b1;
        Opcode = 6'b000000;
        test_reset();
        test_rtype_reset();
        test_lw_sw();
        test_back_to_back();
        test_random();
        test_reset_any();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/main_control_fsm.md
MAIN_CONTROL_FSM -- requirements
Module: main_control_fsm

Interface
REQ-001 Parameter SHALL be: STATE_W, 4, state register width (fixed at 4).
REQ-002 Port clk SHALL be: clk  input  1  sole clock; rising-edge state update.
REQ-003 Port reset SHALL be: reset  input  1  asynchronous, active-high reset.
REQ-004 Port SHALL be: Opcode  input  6  instruction[31:26] from instruction register.
REQ-005 Port SHALL be: PCWrite  output  1  unconditional PC load.
REQ-006 Port SHALL be: PCWriteCond  output  1  PC load gated by ALU Zero.
REQ-007 Port SHALL be: IorD  output  1  memory address select (0 PC, 1 ALUOut).
REQ-008 Port SHALL be: MemRead  output  1  memory read enable.
REQ-009 Port SHALL be: MemWrite  output  1  memory write enable.
REQ-010 Port SHALL be: IRWrite  output  1  instruction register load.
REQ-011 Port SHALL be: MemtoReg  output  1  register write data (0 ALUOut, 1 MDR).
REQ-012 Port SHALL be: RegDst  output  1  destination register (0 rt, 1 rd).
REQ-013 Port SHALL be: RegWrite  output  1  register file write enable.
REQ-014 Port SHALL be: ALUSrcA  output  1  ALU input A select (0 PC, 1 Register_A).
REQ-015 Port SHALL be: ALUSrcB  output  2  00 reg B, 01 const 4, 10 sext imm, 11 sext imm<<2.
REQ-016 Port SHALL be: ALUOp  output  2  00 add, 01 sub, 10 funct-decoded.
REQ-017 Port SHALL be: PCSource  output  2  00 ALU result, 01 ALUOut, 10 jump target.
REQ-018 Port SHALL be: State  output  4  current state, for observability.

Function
REQ-019 Moore machine: outputs SHALL decode current state only; any output not listed for a state SHALL be 0.
REQ-020 Encodings SHALL be: FETCH 0, DECODE 1, MEMADR 2, MEMRD 3, MEMWB 4, MEMWR 5, RTYPE_EX 6, RTYPE_WB 7, BEQ_EX 8, JUMP_EX 9, ADDI_EX 10, ADDI_WB 11.
REQ-021 FETCH SHALL drive MemRead=1, IRWrite=1, PCWrite=1, ALUSrcB=01; next DECODE.
REQ-022 DECODE SHALL drive ALUSrcB=11; next by Opcode: 100011/101011 MEMADR, 000000 RTYPE_EX, 000100 BEQ_EX, 000010 JUMP_EX, 001000 ADDI_EX, other FETCH.
REQ-023 MEMADR SHALL drive ALUSrcA=1, ALUSrcB=10; next MEMRD if Opcode=100011, else MEMWR.
REQ-024 MEMRD SHALL drive MemRead=1, IorD=1; next MEMWB.
REQ-025 MEMWB SHALL drive RegWrite=1, MemtoReg=1; next FETCH.
REQ-026 MEMWR SHALL drive MemWrite=1, IorD=1; next FETCH.
REQ-027 RTYPE_EX SHALL drive ALUSrcA=1, ALUOp=10; next RTYPE_WB.
REQ-028 RTYPE_WB SHALL drive RegWrite=1, RegDst=1; next FETCH.
REQ-029 BEQ_EX SHALL drive ALUSrcA=1, ALUOp=01, PCWriteCond=1, PCSource=01; next FETCH.
REQ-030 JUMP_EX SHALL drive PCWrite=1, PCSource=10; next FETCH.
REQ-031 ADDI_EX SHALL drive ALUSrcA=1, ALUSrcB=10; next ADDI_WB.
REQ-032 ADDI_WB SHALL drive RegWrite=1 (RegDst=0, MemtoReg=0); next FETCH.
REQ-033 Cycles FETCH-to-FETCH SHALL be: lw 5, sw 4, R-type 4, addi 4, beq 3, j 3, unknown 2.
REQ-034 Opcode SHALL be sampled only in DECODE and MEMADR; changes elsewhere SHALL not alter the sequence.
REQ-035 Unused codes 12-15 SHALL drive all outputs 0 and go to FETCH next.
REQ-036 MemRead/MemWrite SHALL never both be 1; likewise PCWrite/PCWriteCond.

Reset
REQ-037 reset=1 SHALL force FETCH immediately, independent of clk, held while high; outputs take FETCH values (datapath PC reset dominates PCWrite).
REQ-038 Reset in any state SHALL abandon the instruction; first rising clk after deassertion SHALL move FETCH to DECODE.

Structure
REQ-039 Shared package mips_ctrl_pkg SHALL hold state encodings, opcode constants (OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_J, OP_ADDI), ALUOp, ALUSrcB and PCSource codes.
REQ-040 One sub-module control_decode SHALL map state to control word; state register and next-state logic stay in main_control_fsm.

Verification
REQ-041 Reset asserted during RTYPE_EX, released, Opcode=000000 -> State 0 at once, then 0,1,6,7,0; RegWrite=1 only in 7 with RegDst=1.
REQ-042 Opcode=100011 -> 0,1,2,3,4,0; MemRead=1 in 0 and 3, IorD=1 in 3, RegWrite=MemtoReg=1 in 4.
REQ-043 Opcode=101011 -> 0,1,2,5,0; MemWrite=1 only in 5, MemRead=0 there.
REQ-044 Opcode=000100 then 000010 -> 0,1,8,0,1,9,0; PCWriteCond=1, PCSource=01 in 8; PCWrite=1, PCSource=10 in 9.
REQ-045 Opcode=111111 -> 0,1,0 repeating, RegWrite/MemWrite never 1; Opcode changed during lw state 3 -> sequence unchanged.
